clk_edge_counter: RTL and testbench

Synthesizable on-chip frequency monitor for clocks derived from the digital PLL and the clock divider, e.g. core or user clock divided down and routed to a GPIO. Counts rising edges of an asynchronous monitored signal over a programmable window of reference-clock cycles and reports the count through a valid/ack handshake. This replaces external edge counting on mprj_io[14]/[15] with a firmware-readable result that the management SoC can check directly.

---
 rtl/clk_mon_pkg.sv | 15 +
 rtl/clk_edge_counter_sync.sv | 38 +++
 rtl/clk_edge_counter.sv | 158 +++++++++++++++
 tb/tb_clk_edge_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default sizes for the clock edge-counting frequency monitor.
// The monitor FSM walks IDLE -> MEASURE -> DONE, or loops in MEASURE in continuous mode.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_edge_counter_sync.sv
// Synchronizer chain plus rising-edge detector for an asynchronous single-bit input.
// Runs in every FSM state so that the edge history is valid whenever a window opens.
module edge_sync_detect
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF  // legal range 2..4
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;

endmodule

// File: rtl/clk_edge_counter.sv
// Frequency monitor: counts synchronized rising edges of mon_in over a programmable
// window of reference-clock cycles and hands the result out through a valid/ack pair.
module clk_edge_counter
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mon_in,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  input  logic             count_ack,
  output logic             overflow,
  output logic             overrun
);

  // Returns {saturated, next_value}; the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
    if (inc && (&val)) return {1'b1, val};
    return {1'b0, val + CNT_W'(inc)};
  endfunction

  logic rise;
  logic mon_sync;

  edge_sync_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (mon_in),
    .sync_out (mon_sync),
    .rise     (rise)
  );

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             cont_q, cont_d;
  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic             overflow_q, overflow_d;
  logic             overrun_q, overrun_d;

  logic [CNT_W-1:0] ecnt_inc;
  logic             sat_hit;
  logic             ovf_inc;
  logic             last_cycle;

  always_comb begin
    {sat_hit, ecnt_inc} = sat_inc(ecnt_q, rise);
    ovf_inc    = ovf_q | sat_hit;
    last_cycle = (wcnt_q == (win_q - WIN_W'(1)));
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    cont_d        = cont_q;
    wcnt_d        = wcnt_q;
    ecnt_d        = ecnt_q;
    ovf_d         = ovf_q;
    count_d       = count_q;
    count_valid_d = count_valid_q;
    overflow_d    = overflow_q;
    overrun_d     = overrun_q;

    // A result load later in this block overrides the acknowledge.
    if (count_ack) count_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          win_d     = window;
          cont_d    = continuous;
          wcnt_d    = '0;
          ecnt_d    = '0;
          ovf_d     = 1'b0;
          overrun_d = 1'b0;
          if (window == '0) begin
            state_d       = DONE;
            count_d       = '0;
            overflow_d    = 1'b0;
            count_valid_d = 1'b1;
          end else begin
            state_d = MEASURE;
          end
        end
      end

      MEASURE: begin
        wcnt_d = wcnt_q + WIN_W'(1);
        ecnt_d = ecnt_inc;
        ovf_d  = ovf_inc;
        if (last_cycle) begin
          count_d       = ecnt_inc;
          overflow_d    = ovf_inc;
          count_valid_d = 1'b1;
          if (cont_q) begin
            wcnt_d = '0;
            ecnt_d = '0;
            ovf_d  = 1'b0;
            if (count_valid_q && !count_ack) overrun_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (count_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
      overrun_q     <= overrun_d;
    end
  end

  // Working registers are always reinitialised at start accept, so they carry no reset.
  always_ff @(posedge clock) begin
    win_q  <= win_d;
    cont_q <= cont_d;
    wcnt_q <= wcnt_d;
    ecnt_q <= ecnt_d;
    ovf_q  <= ovf_d;
  end

  assign busy        = (state_q == MEASURE);
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_clk_edge_counter.sv
// Bench for clk_edge_counter: a 16-bit and a 4-bit instance share stimulus; expected counts
// come from a timestamp list of mon_in rising edges seen at the reference clock.
module tb_clk_edge_counter;

  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mon_in = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        count_ack = 1'b0;
  logic [15:0] window = '0;

  logic        busy, count_valid, overflow, overrun;
  logic [15:0] count;
  logic        busy4, count_valid4, overflow4, overrun4;
  logic [3:0]  count4;

  clk_edge_counter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .mon_in(mon_in), .start(start),
    .continuous(continuous), .window(window), .busy(busy), .count(count),
    .count_valid(count_valid), .count_ack(count_ack), .overflow(overflow),
    .overrun(overrun)
  );

  clk_edge_counter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(SYNC)) dut4 (
    .clock(clock), .reset(reset), .mon_in(mon_in), .start(start),
    .continuous(continuous), .window(window), .busy(busy4), .count(count4),
    .count_valid(count_valid4), .count_ack(count_ack), .overflow(overflow4),
    .overrun(overrun4)
  );

  always #10 clock = ~clock;

  // Reference: clock-edge index at which each mon_in rising edge is due to be counted.
  int   cyc = 0;
  logic mon_prev = 1'b0;
  int   rise_t[$];

  always @(posedge clock) begin
    if (mon_in && !mon_prev) rise_t.push_back(cyc + 1 + SYNC);
    mon_prev <= mon_in;
    cyc      <= cyc + 1;
  end

  int mon_hi = 5;
  int mon_lo = 5;

  initial begin
    forever begin
      repeat (mon_lo) @(negedge clock);
      mon_in = 1'b1;
      repeat (mon_hi) @(negedge clock);
      mon_in = 1'b0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rises_in(input int lo, input int hi);
    int n = 0;
    foreach (rise_t[i]) if (rise_t[i] >= lo && rise_t[i] <= hi) n++;
    return n;
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int acc;

  task automatic do_start(input int w, input bit c);
    window     = 16'(w);
    continuous = c;
    start      = 1'b1;
    tick();
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_result(input int w, output int busy_n, output int lat);
    busy_n = 0;
    lat    = 0;
    while (!count_valid && lat < w + 50) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    chk("result_seen", int'(count_valid), 1);
  endtask

  task automatic do_ack(input string tag);
    count_ack = 1'b1;
    tick();
    count_ack = 1'b0;
    chk({tag, "_ack_valid"}, int'(count_valid), 0);
    chk({tag, "_ack_busy"}, int'(busy), 0);
  endtask

  task automatic single(input string tag, input int w);
    int bn, lat, exp;
    do_start(w, 1'b0);
    wait_result(w, bn, lat);
    exp = rises_in(acc + 1, acc + w);
    chk({tag, "_busy_len"}, bn, w);
    chk({tag, "_latency"}, lat, w);
    chk({tag, "_count"}, int'(count), exp);
    chk({tag, "_overflow"}, int'(overflow), 0);
    do_ack(tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, lat, exp, raw, a0, drops;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(count_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_overrun", int'(overrun), 0);
    repeat (5) tick();

    // 200 ns mon_in period, 1000-cycle window
    mon_hi = 5; mon_lo = 5;
    single("base", 1000);
    chk("base_range", int'(count >= 99 && count <= 101), 1);

    for (int k = 0; k < 3; k++) begin
      mon_hi = int'($urandom_range(2, 6));
      mon_lo = int'($urandom_range(3, 8));
      single($sformatf("rnd%0d", k), int'($urandom_range(20, 400)));
    end

    // 100 ns period over 200 cycles saturates the 4-bit instance
    mon_hi = 2; mon_lo = 3;
    do_start(200, 1'b0);
    wait_result(200, bn, lat);
    raw = rises_in(acc + 1, acc + 200);
    chk("sat_count16", int'(count), raw);
    chk("sat_overflow16", int'(overflow), 0);
    chk("sat_count4", int'(count4), sat(raw, 15));
    chk("sat_overflow4", int'(overflow4), int'(raw > 15));
    do_ack("sat");

    // zero-length window
    do_start(0, 1'b0);
    chk("w0_valid", int'(count_valid), 1);
    chk("w0_count", int'(count), 0);
    chk("w0_busy", int'(busy), 0);
    chk("w0_count4", int'(count4), 0);
    chk("w0_overflow4", int'(overflow4), 0);
    tick();
    chk("w0_busy_later", int'(busy), 0);
    do_ack("w0");

    // start ignored while measuring and while holding a result
    mon_hi = int'($urandom_range(2, 6));
    mon_lo = int'($urandom_range(3, 8));
    do_start(100, 1'b0);
    repeat (29) tick();
    window = 16'd7;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_result(100, bn, lat);
    exp = rises_in(acc + 1, acc + 100);
    chk("ign_len", 30 + lat, 100);
    chk("ign_count", int'(count), exp);
    window     = 16'd3;
    continuous = 1'b1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    continuous = 1'b0;
    repeat (4) tick();
    chk("ign_done_valid", int'(count_valid), 1);
    chk("ign_done_busy", int'(busy), 0);
    chk("ign_done_count", int'(count), exp);
    do_ack("ign");

    // continuous mode, never acknowledged
    mon_hi = 5; mon_lo = 5;
    do_start(500, 1'b1);
    a0    = acc;
    drops = 0;
    for (int k = 1; k <= 3; k++) begin
      repeat (500) begin
        tick();
        if (!busy) drops++;
      end
      exp = rises_in(a0 + (k - 1) * 500 + 1, a0 + k * 500);
      chk($sformatf("cont%0d_count", k), int'(count), exp);
      chk($sformatf("cont%0d_valid", k), int'(count_valid), 1);
      chk($sformatf("cont%0d_overrun", k), int'(overrun), int'(k >= 2));
    end
    chk("cont_busy_drops", drops, 0);
    chk("cont_range", int'(count >= 49 && count <= 51), 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cont_rst_busy", int'(busy), 0);
    chk("cont_rst_valid", int'(count_valid), 0);
    chk("cont_rst_overrun", int'(overrun), 0);
    chk("cont_rst_count", int'(count), 0);
    repeat (5) tick();

    // reset in the middle of a window, then a fresh full window
    do_start(1000, 1'b0);
    repeat (299) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(count_valid), 0);
    repeat (5) tick();
    single("post_rst", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
